// File: rtl/rotdc_event_decoder.sv
// Linearises ring-oscillator TDC start/stop snapshots into timestamps and pairs them into intervals.
// Three decode stages feed a registered pairing FSM; no backpressure, one snapshot accepted per cycle.
module rotdc_event_decoder #(
  parameter int ROLEN_HALF  = 126,
  parameter int COUNTER_LEN = 64,
  parameter int FINE_W      = 9,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          snap_valid,
  input  logic                          snap_is_stop,
  input  logic [2*ROLEN_HALF+2:0]       snap_ring,
  input  logic [COUNTER_LEN-1:0]        snap_coarse,
  output logic                          res_valid,
  output logic [COUNTER_LEN+FINE_W-1:0] res_interval,
  output logic                          res_bubble,
  output logic                          err_order,
  output logic                          err_restart,
  output logic                          err_timeout,
  output logic                          busy
);
  localparam int STAGES = 2*ROLEN_HALF+3;
  localparam int TS_W   = COUNTER_LEN+FINE_W;
  localparam int IDX_W  = $clog2(STAGES);
  localparam int CNT_W  = $clog2(TIMEOUT_CYC+1);

  typedef enum logic {IDLE, ARMED} state_t;

  // S1: raw snapshot capture
  logic                   s1_vld_q, s1_stop_q;
  logic [STAGES-1:0]      s1_ring_q;
  logic [COUNTER_LEN-1:0] s1_coarse_q;

  // S2: edge vector and bubble detection
  logic                   s2_vld_q, s2_stop_q, s2_bub_q, s2_bub_d;
  logic [STAGES-1:0]      s2_edge_q, s2_edge_d, s2_ring_q;
  logic [COUNTER_LEN-1:0] s2_coarse_q;

  // S3: decoded timestamp
  logic                   s3_vld_q, s3_stop_q, s3_bub_q;
  logic [TS_W-1:0]        s3_ts_q, s3_ts_d;
  logic [IDX_W-1:0]       idx;
  logic [FINE_W-1:0]      fine;

  // Pairing FSM and registered outputs
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [TS_W-1:0]        start_ts_q, start_ts_d;
  logic                   start_bub_q, start_bub_d;
  logic                   res_valid_q, res_valid_d;
  logic [TS_W-1:0]        res_interval_q, res_interval_d;
  logic                   res_bubble_q, res_bubble_d;
  logic                   err_order_q, err_order_d;
  logic                   err_restart_q, err_restart_d;
  logic                   err_timeout_q, err_timeout_d;

  always_comb begin
    s2_edge_d = '0;
    for (int i = 0; i < STAGES; i++) begin
      s2_edge_d[i] = ~(s1_ring_q[i] ^ s1_ring_q[(i+1) % STAGES]);
    end
    s2_bub_d = ((s2_edge_d & (s2_edge_d - STAGES'(1))) != '0) || (s2_edge_d == '0);
  end

  // Lowest set edge wins; scanning downward leaves the smallest index last.
  always_comb begin
    idx = '0;
    for (int i = STAGES-1; i >= 0; i--) begin
      if (s2_edge_q[i]) idx = IDX_W'(i);
    end
    fine    = s2_ring_q[idx] ? FINE_W'(idx) : FINE_W'(idx) + FINE_W'(STAGES);
    s3_ts_d = TS_W'(s2_coarse_q) * TS_W'(2*STAGES) + TS_W'(fine);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_q    <= 1'b0;
      s1_stop_q   <= 1'b0;
      s1_ring_q   <= '0;
      s1_coarse_q <= '0;
      s2_vld_q    <= 1'b0;
      s2_stop_q   <= 1'b0;
      s2_bub_q    <= 1'b0;
      s2_edge_q   <= '0;
      s2_ring_q   <= '0;
      s2_coarse_q <= '0;
      s3_vld_q    <= 1'b0;
      s3_stop_q   <= 1'b0;
      s3_bub_q    <= 1'b0;
      s3_ts_q     <= '0;
    end else begin
      s1_vld_q    <= snap_valid;
      s1_stop_q   <= snap_is_stop;
      s1_ring_q   <= snap_ring;
      s1_coarse_q <= snap_coarse;
      s2_vld_q    <= s1_vld_q;
      s2_stop_q   <= s1_stop_q;
      s2_bub_q    <= s2_bub_d;
      s2_edge_q   <= s2_edge_d;
      s2_ring_q   <= s1_ring_q;
      s2_coarse_q <= s1_coarse_q;
      s3_vld_q    <= s2_vld_q;
      s3_stop_q   <= s2_stop_q;
      s3_bub_q    <= s2_bub_q;
      s3_ts_q     <= s3_ts_d;
    end
  end

  // A decoded event in the timeout cycle takes precedence over the timeout.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    start_ts_d     = start_ts_q;
    start_bub_d    = start_bub_q;
    res_valid_d    = 1'b0;
    res_interval_d = res_interval_q;
    res_bubble_d   = res_bubble_q;
    err_order_d    = 1'b0;
    err_restart_d  = 1'b0;
    err_timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (s3_vld_q) begin
          if (s3_stop_q) begin
            err_order_d = 1'b1;
          end else begin
            state_d     = ARMED;
            start_ts_d  = s3_ts_q;
            start_bub_d = s3_bub_q;
            cnt_d       = '0;
          end
        end
      end
      ARMED: begin
        if (s3_vld_q && s3_stop_q) begin
          res_valid_d    = 1'b1;
          res_interval_d = s3_ts_q - start_ts_q;
          res_bubble_d   = start_bub_q | s3_bub_q;
          state_d        = IDLE;
        end else if (s3_vld_q) begin
          err_restart_d = 1'b1;
          start_ts_d    = s3_ts_q;
          start_bub_d   = s3_bub_q;
          cnt_d         = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC-1)) begin
          err_timeout_d = 1'b1;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      start_ts_q     <= '0;
      start_bub_q    <= 1'b0;
      res_valid_q    <= 1'b0;
      res_interval_q <= '0;
      res_bubble_q   <= 1'b0;
      err_order_q    <= 1'b0;
      err_restart_q  <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      start_ts_q     <= start_ts_d;
      start_bub_q    <= start_bub_d;
      res_valid_q    <= res_valid_d;
      res_interval_q <= res_interval_d;
      res_bubble_q   <= res_bubble_d;
      err_order_q    <= err_order_d;
      err_restart_q  <= err_restart_d;
      err_timeout_q  <= err_timeout_d;
    end
  end

  assign res_valid    = res_valid_q;
  assign res_interval = res_interval_q;
  assign res_bubble   = res_bubble_q;
  assign err_order    = err_order_q;
  assign err_restart  = err_restart_q;
  assign err_timeout  = err_timeout_q;
  assign busy         = (state_q == ARMED);

endmodule

// File: tb/tb_rotdc_event_decoder.sv
// Bench for rotdc_event_decoder: directed scenarios then random snapshots, every output checked each cycle
// against a timestamp/deadline reference model.
module tb_rotdc_event_decoder;
  localparam int ROLEN_HALF  = 126;
  localparam int COUNTER_LEN = 64;
  localparam int FINE_W      = 9;
  localparam int TIMEOUT_CYC = 4096;
  localparam int STAGES      = 2*ROLEN_HALF+3;
  localparam int TS_W        = COUNTER_LEN+FINE_W;

  typedef logic [STAGES-1:0] ring_t;
  typedef logic [TS_W-1:0]   ts_t;
  typedef struct {
    bit  vld;
    bit  stop;
    ts_t ts;
    bit  bub;
  } ev_t;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   snap_valid;
  logic                   snap_is_stop;
  ring_t                  snap_ring;
  logic [COUNTER_LEN-1:0] snap_coarse;
  logic                   res_valid;
  ts_t                    res_interval;
  logic                   res_bubble;
  logic                   err_order;
  logic                   err_restart;
  logic                   err_timeout;
  logic                   busy;

  rotdc_event_decoder #(
    .ROLEN_HALF (ROLEN_HALF),
    .COUNTER_LEN(COUNTER_LEN),
    .FINE_W     (FINE_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .snap_valid  (snap_valid),
    .snap_is_stop(snap_is_stop),
    .snap_ring   (snap_ring),
    .snap_coarse (snap_coarse),
    .res_valid   (res_valid),
    .res_interval(res_interval),
    .res_bubble  (res_bubble),
    .err_order   (err_order),
    .err_restart (err_restart),
    .err_timeout (err_timeout),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int     n_vec = 0;
  int     n_err = 0;
  longint edge_no = 0;

  ev_t    pipe[$];
  bit     armed;
  ts_t    start_ts;
  bit     start_bub;
  longint arm_edge;

  bit     exp_valid, exp_bubble, exp_order, exp_restart, exp_timeout, exp_busy;
  ts_t    exp_interval;

  task automatic chk(input string tag, input ts_t got, input ts_t want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s @edge %0d: got 0x%0h, want 0x%0h", tag, edge_no, got, want);
    end
  endtask

  // Reference decode: count equal-neighbour pairs around the ring, take the first one.
  function automatic void decode(input ring_t r, input logic [63:0] c, output ts_t ts, output bit bub);
    int n_edges = 0;
    int first   = -1;
    int fine;
    for (int i = 0; i < STAGES; i++) begin
      if (r[i] == r[(i+1) % STAGES]) begin
        n_edges++;
        if (first < 0) first = i;
      end
    end
    if (first < 0) first = 0;
    fine = r[first] ? first : first + STAGES;
    ts   = ts_t'(c) * ts_t'(2*STAGES) + ts_t'(fine);
    bub  = (n_edges != 1);
  endfunction

  // Builds a ring whose equal-neighbour positions are exactly the set bits of e (odd count), with ring[k] = v.
  function automatic ring_t ring_with_edges(input ring_t e, input int k, input bit v);
    ring_t r = '0;
    for (int i = 0; i < STAGES-1; i++) r[i+1] = e[i] ? r[i] : ~r[i];
    if (r[k] != v) r = ~r;
    return r;
  endfunction

  function automatic ring_t one_edge(input int k);
    ring_t e = '0;
    e[k] = 1'b1;
    return e;
  endfunction

  // Expected outputs after the coming clock edge, given the inputs presented to it.
  task automatic model_edge(input bit rst, input bit vld, input bit stop, input ring_t r, input logic [63:0] c);
    ev_t ev, nw, z;
    edge_no++;
    exp_valid   = 1'b0;
    exp_order   = 1'b0;
    exp_restart = 1'b0;
    exp_timeout = 1'b0;
    if (rst) begin
      z.vld = 1'b0; z.stop = 1'b0; z.ts = '0; z.bub = 1'b0;
      pipe.delete();
      for (int i = 0; i < 3; i++) pipe.push_back(z);
      armed        = 1'b0;
      exp_interval = '0;
      exp_bubble   = 1'b0;
      exp_busy     = 1'b0;
      return;
    end
    nw.vld  = vld;
    nw.stop = stop;
    decode(r, c, nw.ts, nw.bub);
    ev = pipe.pop_front();
    pipe.push_back(nw);
    if (ev.vld && ev.stop) begin
      if (armed) begin
        exp_valid    = 1'b1;
        exp_interval = ev.ts - start_ts;
        exp_bubble   = start_bub | ev.bub;
        armed        = 1'b0;
      end else begin
        exp_order = 1'b1;
      end
    end else if (ev.vld) begin
      if (armed) exp_restart = 1'b1;
      armed     = 1'b1;
      start_ts  = ev.ts;
      start_bub = ev.bub;
      arm_edge  = edge_no;
    end else if (armed && (edge_no - arm_edge == TIMEOUT_CYC)) begin
      exp_timeout = 1'b1;
      armed       = 1'b0;
    end
    exp_busy = armed;
  endtask

  task automatic check_outputs();
    chk("res_valid",    ts_t'(res_valid),   ts_t'(exp_valid));
    chk("res_interval", res_interval,       exp_interval);
    chk("res_bubble",   ts_t'(res_bubble),  ts_t'(exp_bubble));
    chk("err_order",    ts_t'(err_order),   ts_t'(exp_order));
    chk("err_restart",  ts_t'(err_restart), ts_t'(exp_restart));
    chk("err_timeout",  ts_t'(err_timeout), ts_t'(exp_timeout));
    chk("busy",         ts_t'(busy),        ts_t'(exp_busy));
  endtask

  task automatic step(input bit rst, input bit vld, input bit stop, input ring_t r, input logic [63:0] c);
    @(negedge clk);
    check_outputs();
    rst_n        = ~rst;
    snap_valid   = vld;
    snap_is_stop = stop;
    snap_ring    = r;
    snap_coarse  = c;
    model_edge(rst, vld, stop, r, c);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    ring_t       r;
    logic [63:0] c;
    bit          rst, vld, stp;
    int          k;

    rst_n        = 1'b0;
    snap_valid   = 1'b0;
    snap_is_stop = 1'b0;
    snap_ring    = '0;
    snap_coarse  = '0;
    model_edge(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (3) step(1'b1, 1'b0, 1'b0, '0, '0);
    idle(3);

    // Basic pair: 5*510+265 = 2815 to 7*510+3 = 3573.
    step(1'b0, 1'b1, 1'b0, ring_with_edges(one_edge(10), 10, 1'b0), 64'd5);
    step(1'b0, 1'b1, 1'b1, ring_with_edges(one_edge(3), 3, 1'b1), 64'd7);
    idle(5);
    chk("basic_interval", res_interval, ts_t'(758));
    chk("basic_bubble", ts_t'(res_bubble), ts_t'(0));

    // Coarse wrap: the timestamp wraps at 2^73, so 530 lands in the low 64 bits.
    step(1'b0, 1'b1, 1'b0, ring_with_edges(one_edge(0), 0, 1'b1), '1);
    idle(2);
    step(1'b0, 1'b1, 1'b1, ring_with_edges(one_edge(20), 20, 1'b1), 64'd0);
    idle(5);
    chk("wrap_lo64", ts_t'(res_interval[63:0]), ts_t'(530));

    // Orphan stop, then a normal pair.
    step(1'b0, 1'b1, 1'b1, ring_with_edges(one_edge(30), 30, 1'b0), 64'd3);
    idle(4);
    step(1'b0, 1'b1, 1'b0, ring_with_edges(one_edge(40), 40, 1'b1), 64'd10);
    step(1'b0, 1'b1, 1'b1, ring_with_edges(one_edge(41), 41, 1'b1), 64'd11);
    idle(5);
    chk("after_order_interval", res_interval, ts_t'(511));

    // Restart: measured from the second start (102*510+325) - (101*510+60).
    step(1'b0, 1'b1, 1'b0, ring_with_edges(one_edge(50), 50, 1'b0), 64'd100);
    idle(2);
    step(1'b0, 1'b1, 1'b0, ring_with_edges(one_edge(60), 60, 1'b1), 64'd101);
    idle(1);
    step(1'b0, 1'b1, 1'b1, ring_with_edges(one_edge(70), 70, 1'b0), 64'd102);
    idle(5);
    chk("restart_interval", res_interval, ts_t'(775));

    // Multi-edge start; an odd ring always has an odd edge count, so a third edge sits far away.
    r = one_edge(4) | one_edge(6) | one_edge(200);
    step(1'b0, 1'b1, 1'b0, ring_with_edges(r, 4, 1'b1), 64'd9);
    step(1'b0, 1'b1, 1'b1, ring_with_edges(one_edge(8), 8, 1'b1), 64'd9);
    idle(5);
    chk("bubble_flag", ts_t'(res_bubble), ts_t'(1));
    chk("bubble_interval", res_interval, ts_t'(4));

    // Timeout with no stop.
    step(1'b0, 1'b1, 1'b0, ring_with_edges(one_edge(12), 12, 1'b1), 64'd2);
    idle(TIMEOUT_CYC + 6);
    chk("timeout_busy_low", ts_t'(busy), ts_t'(0));

    // Stop decoded in the very cycle the timeout would fire.
    step(1'b0, 1'b1, 1'b0, ring_with_edges(one_edge(10), 10, 1'b1), 64'd1);
    idle(TIMEOUT_CYC - 1);
    step(1'b0, 1'b1, 1'b1, ring_with_edges(one_edge(11), 11, 1'b1), 64'd1);
    idle(5);
    chk("deadline_stop_interval", res_interval, ts_t'(1));

    // Reset while armed, then a stop three cycles later is an orphan.
    step(1'b0, 1'b1, 1'b0, ring_with_edges(one_edge(90), 90, 1'b0), 64'd44);
    idle(5);
    step(1'b1, 1'b0, 1'b0, '0, '0);
    idle(2);
    step(1'b0, 1'b1, 1'b1, ring_with_edges(one_edge(91), 91, 1'b0), 64'd45);
    idle(5);

    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      vld = ($urandom_range(0, 99) < 35);
      stp = 1'($urandom_range(0, 1));
      c   = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < STAGES; i++) r[i] = 1'($urandom_range(0, 1));
      end else begin
        k = $urandom_range(0, STAGES-1);
        r = ring_with_edges(one_edge(k), k, 1'($urandom_range(0, 1)));
      end
      step(rst, vld, stp, r, c);
    end
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
